// File: rtl/tmds_decoder_dvi_rx.sv
// ---------------------------------------------------------------------------
// TmdsDecoderDviRx (module tmds_decoder_dvi_rx)
//
// Purpose:
//   Receive side of one DVI TMDS channel. An upstream deserialiser delivers
//   one raw 10-bit word per pixel clock. The word boundary in that stream is
//   not known, so this block slides a 10-bit window across two consecutive
//   raw words. It locks onto the offset that shows a run of TMDS control
//   tokens, then decodes every aligned word into pixel data, control bits
//   and a data-enable flag. Use one instance per TMDS channel.
//
// Parameters:
//   LOCK_COUNT    - consecutive control tokens at one offset needed to lock
//   SEARCH_WINDOW - cycles spent at one offset before slipping to the next
//   LOSS_TIMEOUT  - token-free cycles tolerated while locked
//
// Ports:
//   clk_pix    in   1  pixel clock, the only clock
//   rst_pix    in   1  synchronous active-high reset
//   tmds_in    in  10  raw deserialised word, bit 0 was first on the wire
//   data_out   out  8  decoded pixel data, 0 when de_out is low
//   ctrl_out   out  2  decoded control bits {c1,c0}, held through data
//   de_out     out  1  high for a decoded data word, low while unlocked
//   locked     out  1  word alignment achieved
//   bit_offset out  4  current window offset, 0..9
//
// Latency: with bit_offset = 0, a word on tmds_in in cycle n reaches the
// outputs in cycle n+3 (prev register, window register, output register).
// ---------------------------------------------------------------------------
module tmds_decoder_dvi_rx #(
    parameter int LOCK_COUNT    = 8,
    parameter int SEARCH_WINDOW = 4096,
    parameter int LOSS_TIMEOUT  = 8192
) (
    input  logic       clk_pix,
    input  logic       rst_pix,
    input  logic [9:0] tmds_in,
    output logic [7:0] data_out,
    output logic [1:0] ctrl_out,
    output logic       de_out,
    output logic       locked,
    output logic [3:0] bit_offset
);

    localparam int RUN_W = $clog2(LOCK_COUNT) + 1;
    localparam int WIN_W = $clog2(SEARCH_WINDOW) + 1;
    localparam int GAP_W = $clog2(LOSS_TIMEOUT) + 1;

    // Terminal values: the cycle on which a counter sits at its last value
    // is the cycle on which the limit is reached.
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_COUNT - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SEARCH_WINDOW - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(LOSS_TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Pipeline registers
    logic [9:0]       r_prev;
    logic [9:0]       r_win;

    // Alignment state
    state_t           r_state;
    logic [3:0]       r_offset;
    logic [RUN_W-1:0] r_runCnt;
    logic [WIN_W-1:0] r_winCnt;
    logic [GAP_W-1:0] r_gapCnt;
    logic [1:0]       r_settle;

    // Output registers
    logic [7:0]       r_data;
    logic [1:0]       r_ctrl;
    logic             r_de;

    // Combinational signals
    logic [18:0]      w_cat;
    logic [9:0]       w_window;
    logic             w_isToken;
    logic [1:0]       w_tokenCtrl;
    logic [7:0]       w_dInv;
    logic [7:0]       w_decoded;

    state_t           w_stateNext;
    logic [3:0]       w_offsetNext;
    logic [RUN_W-1:0] w_runNext;
    logic [WIN_W-1:0] w_winNext;
    logic [GAP_W-1:0] w_gapNext;
    logic [1:0]       w_settleNext;

    // The window never needs the top bit of the current word: the largest
    // offset (9) takes bits 18..9 of {current, previous}. tmds_in[9] still
    // enters the design through r_prev.
    assign w_cat = {tmds_in[8:0], r_prev};

    // Select the 10-bit window starting at the current offset. Bit 0 of the
    // window is the earliest bit of the aligned word.
    always_comb begin
        w_window = w_cat[9:0];
        case (r_offset)
            4'd0:    w_window = w_cat[9:0];
            4'd1:    w_window = w_cat[10:1];
            4'd2:    w_window = w_cat[11:2];
            4'd3:    w_window = w_cat[12:3];
            4'd4:    w_window = w_cat[13:4];
            4'd5:    w_window = w_cat[14:5];
            4'd6:    w_window = w_cat[15:6];
            4'd7:    w_window = w_cat[16:7];
            4'd8:    w_window = w_cat[17:8];
            4'd9:    w_window = w_cat[18:9];
            default: w_window = w_cat[9:0];
        endcase
    end

    // Stage 1: remember the previous raw word and register the window.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            r_prev <= '0;
            r_win  <= '0;
        end else begin
            r_prev <= tmds_in;
            r_win  <= w_window;
        end
    end

    // Recognise the four TMDS control tokens on the registered window.
    always_comb begin
        w_isToken   = 1'b1;
        w_tokenCtrl = 2'b00;
        case (r_win)
            10'b1101010100: w_tokenCtrl = 2'b00;
            10'b0010101011: w_tokenCtrl = 2'b01;
            10'b0101010100: w_tokenCtrl = 2'b10;
            10'b1010101011: w_tokenCtrl = 2'b11;
            default:        w_isToken   = 1'b0;
        endcase
    end

    // TMDS data decode: bit 9 says the low byte was inverted by the encoder,
    // bit 8 says whether XOR (1) or XNOR (0) chaining was used.
    always_comb begin
        w_decoded    = '0;
        w_dInv       = r_win[9] ? ~r_win[7:0] : r_win[7:0];
        w_decoded[0] = w_dInv[0];
        for (int i = 1; i < 8; i++) begin
            w_decoded[i] = r_win[8] ? (w_dInv[i] ^ w_dInv[i-1])
                                    : ~(w_dInv[i] ^ w_dInv[i-1]);
        end
    end

    // Alignment state register and its counters.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            r_state  <= ST_SEARCH;
            r_offset <= '0;
            r_runCnt <= '0;
            r_winCnt <= '0;
            r_gapCnt <= '0;
            r_settle <= '0;
        end else begin
            r_state  <= w_stateNext;
            r_offset <= w_offsetNext;
            r_runCnt <= w_runNext;
            r_winCnt <= w_winNext;
            r_gapCnt <= w_gapNext;
            r_settle <= w_settleNext;
        end
    end

    // Next-state logic. In SEARCH, a run of tokens at the current offset
    // locks; otherwise the offset slips once the search window expires. A
    // lock seen on the final window cycle wins over the slip. After a slip,
    // r_win still holds a window taken at the old offset, so the settle
    // counter keeps the next two windows out of the token run.
    always_comb begin
        w_stateNext  = r_state;
        w_offsetNext = r_offset;
        w_runNext    = r_runCnt;
        w_winNext    = r_winCnt;
        w_gapNext    = r_gapCnt;
        w_settleNext = r_settle;

        case (r_state)
            ST_SEARCH: begin
                w_winNext = r_winCnt + WIN_W'(1);

                if (r_settle != 2'd0) begin
                    w_settleNext = r_settle - 2'd1;
                end else if (w_isToken) begin
                    w_runNext = r_runCnt + RUN_W'(1);
                end else begin
                    w_runNext = '0;
                end

                if ((r_settle == 2'd0) && w_isToken && (r_runCnt == RUN_LAST)) begin
                    w_stateNext = ST_LOCKED;
                    w_runNext   = '0;
                    w_winNext   = '0;
                    w_gapNext   = '0;
                end else if (r_winCnt == WIN_LAST) begin
                    w_offsetNext = (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;
                    w_runNext    = '0;
                    w_winNext    = '0;
                    w_settleNext = 2'd2;
                end
            end

            ST_LOCKED: begin
                // The offset is frozen here; only the token gap is watched.
                if (w_isToken) begin
                    w_gapNext = '0;
                end else if (r_gapCnt == GAP_LAST) begin
                    w_stateNext  = ST_SEARCH;
                    w_runNext    = '0;
                    w_winNext    = '0;
                    w_gapNext    = '0;
                    w_settleNext = 2'd0;
                end else begin
                    w_gapNext = r_gapCnt + GAP_W'(1);
                end
            end

            default: begin
                w_stateNext = ST_SEARCH;
            end
        endcase
    end

    // Stage 2: register decoded outputs. Control bits follow every token,
    // even while searching, so they are valid as soon as alignment is right.
    // Data and DE are only trusted once the state machine has locked.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            r_data <= '0;
            r_ctrl <= '0;
            r_de   <= 1'b0;
        end else begin
            if (w_isToken) begin
                r_ctrl <= w_tokenCtrl;
            end
            if ((r_state == ST_LOCKED) && !w_isToken) begin
                r_de   <= 1'b1;
                r_data <= w_decoded;
            end else begin
                r_de   <= 1'b0;
                r_data <= '0;
            end
        end
    end

    assign data_out   = r_data;
    assign ctrl_out   = r_ctrl;
    assign de_out     = r_de;
    assign locked     = (r_state == ST_LOCKED);
    assign bit_offset = r_offset;

endmodule

// File: tb/tb_tmds_decoder_dvi_rx.sv
// ---------------------------------------------------------------------------
// tb_tmds_decoder_dvi_rx
//
// Purpose:
//   Testbench for tmds_decoder_dvi_rx. A reference DVI TMDS encoder builds
//   the word stream, which is then cut into raw words with a chosen bit
//   rotation to model an unknown deserialiser phase.
// ---------------------------------------------------------------------------
module tb_tmds_decoder_dvi_rx;

    localparam int LOCK_CNT = 8;
    localparam int SRCH_WIN = 64;
    localparam int LOSS_TO  = 300;

    logic       clk_pix = 1'b0;
    logic       rst_pix;
    logic [9:0] tmds_in;
    logic [7:0] data_out;
    logic [1:0] ctrl_out;
    logic       de_out;
    logic       locked;
    logic [3:0] bit_offset;

    tmds_decoder_dvi_rx #(
        .LOCK_COUNT    (LOCK_CNT),
        .SEARCH_WINDOW (SRCH_WIN),
        .LOSS_TIMEOUT  (LOSS_TO)
    ) dut (
        .clk_pix    (clk_pix),
        .rst_pix    (rst_pix),
        .tmds_in    (tmds_in),
        .data_out   (data_out),
        .ctrl_out   (ctrl_out),
        .de_out     (de_out),
        .locked     (locked),
        .bit_offset (bit_offset)
    );

    always #5 clk_pix = ~clk_pix;

    typedef struct {
        bit         chk;
        logic       de;
        logic [7:0] data;
        logic [1:0] ctrl;
        int         step;
    } exp_t;

    exp_t       sb[$];
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         shiftBits = 0;
    int         encDisp  = 0;
    logic [9:0] prevWord = '0;
    logic [1:0] curCtrl  = 2'b00;

    // Reference DVI 1.0 TMDS data encoder with running disparity.
    function automatic logic [9:0] tmdsEncode(input logic [7:0] d);
        logic [8:0] qm;
        logic [9:0] q;
        int n1, n1q, n0q;
        n1    = $countones(d);
        qm    = '0;
        qm[0] = d[0];
        if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
        end
        n1q = $countones(qm[7:0]);
        n0q = 8 - n1q;
        if (encDisp == 0 || n1q == n0q) begin
            q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            if (qm[8] == 1'b0) encDisp += n0q - n1q;
            else               encDisp += n1q - n0q;
        end else if ((encDisp > 0 && n1q > n0q) || (encDisp < 0 && n0q > n1q)) begin
            q = {1'b1, qm[8], ~qm[7:0]};
            encDisp += (qm[8] ? 2 : 0) + n0q - n1q;
        end else begin
            q = {1'b0, qm[8], qm[7:0]};
            encDisp += -(qm[8] ? 0 : 2) + n1q - n0q;
        end
        return q;
    endfunction

    function automatic logic [9:0] tokenWord(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    // Raw word whose bits [s-1:0] carry the tail of the previous true word
    // and bits [9:s] the head of the current one.
    function automatic logic [9:0] rawWord(input logic [9:0] cur, input logic [9:0] prv, input int s);
        logic [19:0] t;
        t = {cur, prv} >> (10 - s);
        return t[9:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [9:0] word, input bit chk, input logic expDe,
                                 input logic [7:0] expData, input logic [1:0] expCtrl);
        exp_t e;
        @(posedge clk_pix);
        #1;
        cyc++;
        tmds_in  = rawWord(word, prevWord, shiftBits);
        prevWord = word;
        e.chk  = chk;
        e.de   = expDe;
        e.data = expData;
        e.ctrl = expCtrl;
        e.step = cyc;
        sb.push_back(e);
        @(negedge clk_pix);
        if (sb.size() > 3) begin
            e = sb.pop_front();
            if (e.chk) begin
                checkOutput($sformatf("de_out@%0d", e.step),   32'(de_out),   32'(e.de));
                checkOutput($sformatf("data_out@%0d", e.step), 32'(data_out), 32'(e.data));
                checkOutput($sformatf("ctrl_out@%0d", e.step), 32'(ctrl_out), 32'(e.ctrl));
            end
        end
    endtask

    task automatic sendToken(input logic [1:0] c, input bit chk);
        encDisp = 0;
        curCtrl = c;
        applyStimulus(tokenWord(c), chk, 1'b0, 8'h00, c);
    endtask

    task automatic sendData(input logic [7:0] d, input bit chk, input bit lk);
        logic [9:0] w;
        w = tmdsEncode(d);
        applyStimulus(w, chk, lk, (lk ? d : 8'h00), curCtrl);
    endtask

    task automatic doReset();
        @(posedge clk_pix);
        #1;
        rst_pix = 1'b1;
        tmds_in = '0;
        @(posedge clk_pix);
        #1;
        rst_pix  = 1'b0;
        cyc      = 0;
        prevWord = '0;
        encDisp  = 0;
        curCtrl  = 2'b00;
        sb.delete();
        checkOutput("rst_data",   32'(data_out),   32'h0);
        checkOutput("rst_ctrl",   32'(ctrl_out),   32'h0);
        checkOutput("rst_de",     32'(de_out),     32'h0);
        checkOutput("rst_locked", 32'(locked),     32'h0);
        checkOutput("rst_offset", 32'(bit_offset), 32'h0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_pix = 1'b1;
        tmds_in = '0;

        // Alignment at offset 0, then a full data ramp.
        shiftBits = 0;
        doReset();
        for (int k = 1; k <= 100; k++) begin
            sendToken(2'b00, 1'b1);
            if (k == 10) checkOutput("t1_lock_before", 32'(locked), 32'd0);
            if (k == 11) checkOutput("t1_lock_at",     32'(locked), 32'd1);
        end
        checkOutput("t1_offset", 32'(bit_offset), 32'd0);
        for (int v = 0; v < 256; v++) sendData(8'(v), 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) sendToken(2'b00, 1'b1);

        // Alignment at offset 7 with periodic blanking.
        shiftBits = 7;
        doReset();
        for (int k = 1; k <= 470; k++) begin
            if (((k - 1) % 600) >= 400) sendToken(2'b00, (k >= 450));
            else                        sendData(8'(k), 1'b0, 1'b0);
            if ((k % 64) == 63 && k < 448) begin
                checkOutput($sformatf("t2_offset_pre@%0d", k), 32'(bit_offset), 32'(k / 64));
            end
            if ((k % 64) == 0 && k <= 448) begin
                checkOutput($sformatf("t2_offset_step@%0d", k), 32'(bit_offset), 32'(k / 64));
                checkOutput($sformatf("t2_nolock@%0d", k), 32'(locked), 32'd0);
            end
            if (k == 457) checkOutput("t2_lock_before", 32'(locked), 32'd0);
            if (k == 458) checkOutput("t2_lock_at",     32'(locked), 32'd1);
        end
        sendData(8'hA5, 1'b1, 1'b1);
        sendData(8'h3C, 1'b1, 1'b1);
        checkOutput("t2_offset_final", 32'(bit_offset), 32'd7);

        // Control token decode, then ctrl held through data.
        sendToken(2'b01, 1'b1);
        sendToken(2'b10, 1'b1);
        sendToken(2'b11, 1'b1);
        for (int v = 0; v < 6; v++) sendData(8'(v * 37 + 5), 1'b1, 1'b1);
        checkOutput("t3_locked", 32'(locked), 32'd1);

        // Loss of lock after LOSS_TO data-only words, then relock.
        for (int k = 0; k < 4; k++) sendToken(2'b00, 1'b1);
        for (int n = 1; n <= LOSS_TO + 3; n++) begin
            sendData(8'(n * 3), 1'b1, (n <= LOSS_TO));
            if (n == LOSS_TO + 2) checkOutput("t4_lock_before_drop", 32'(locked), 32'd1);
            if (n == LOSS_TO + 3) begin
                checkOutput("t4_lock_dropped", 32'(locked), 32'd0);
                checkOutput("t4_offset_kept",  32'(bit_offset), 32'd7);
            end
        end
        for (int m = 1; m <= 14; m++) begin
            sendToken(2'b00, 1'b1);
            if (m == 10) checkOutput("t4_relock_before", 32'(locked), 32'd0);
            if (m == 11) checkOutput("t4_relock_at",     32'(locked), 32'd1);
        end
        checkOutput("t4_relock_offset", 32'(bit_offset), 32'd7);
        sendData(8'h81, 1'b1, 1'b1);

        // Offset wrap 9 -> 0 with no tokens, then lock at offset 3.
        shiftBits = 3;
        doReset();
        for (int k = 1; k <= 640; k++) begin
            sendData(8'(k * 7), 1'b0, 1'b0);
            if (k == 575) checkOutput("t5_offset_8",    32'(bit_offset), 32'd8);
            if (k == 576) checkOutput("t5_offset_9",    32'(bit_offset), 32'd9);
            if (k == 639) checkOutput("t5_offset_9b",   32'(bit_offset), 32'd9);
            if (k == 640) begin
                checkOutput("t5_offset_wrap", 32'(bit_offset), 32'd0);
                checkOutput("t5_nolock",      32'(locked),     32'd0);
            end
        end
        for (int k = 641; k <= 860; k++) begin
            sendToken(2'b00, (k >= 835));
            if (k == 831) checkOutput("t5_offset_2",      32'(bit_offset), 32'd2);
            if (k == 832) checkOutput("t5_offset_3",      32'(bit_offset), 32'd3);
            if (k == 841) checkOutput("t5_lock_before",   32'(locked),     32'd0);
            if (k == 842) checkOutput("t5_lock_at",       32'(locked),     32'd1);
        end
        for (int v = 0; v < 4; v++) sendData(8'(8'hF0 + v), 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) sendToken(2'b00, 1'b1);

        // Reset while locked, then reacquire at offset 3.
        checkOutput("t6_locked_pre_reset", 32'(locked), 32'd1);
        doReset();
        for (int k = 1; k <= 210; k++) begin
            sendToken(2'b00, (k >= 196));
            if (k == 191) checkOutput("t6_offset_2",    32'(bit_offset), 32'd2);
            if (k == 192) checkOutput("t6_offset_3",    32'(bit_offset), 32'd3);
            if (k == 201) checkOutput("t6_lock_before", 32'(locked),     32'd0);
            if (k == 202) checkOutput("t6_lock_at",     32'(locked),     32'd1);
        end
        for (int v = 0; v < 4; v++) sendData(8'(v * 61 + 2), 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) sendToken(2'b10, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tmds_decoder_dvi_rx.md
Name: tmds_decoder_dvi_rx

Overview:
- Receive-side counterpart of the DVI TMDS encode/serialise path.
- Takes one 10-bit raw word per pixel clock from an upstream per-channel deserialiser. The bit phase of that word is arbitrary.
- Finds word alignment from runs of TMDS control tokens, then decodes to 8-bit data, 2-bit control and data enable.
- One instance per TMDS channel; feeds video capture/timing recovery logic.

Parameters:
- LOCK_COUNT, 8: consecutive control tokens at the current offset required to declare lock.
- SEARCH_WINDOW, 4096: cycles spent at one offset before slipping to the next.
- LOSS_TIMEOUT, 8192: cycles without any control token while locked before lock is dropped.

Ports:
- clk_pix  in  1  pixel clock; the only clock.
- rst_pix  in  1  synchronous, active-high reset.
- tmds_in  in  10  raw deserialised word, one per cycle; bit 0 was received first on the wire.
- data_out  out  8  decoded pixel data; 0 when not de_out.
- ctrl_out  out  2  decoded control bits {c1,c0}; held during data periods.
- de_out  out  1  high for a decoded data word; forced 0 while not locked.
- locked  out  1  alignment achieved.
- bit_offset  out  4  current window offset, 0..9.

Behaviour:
- Reset: all outputs 0; state SEARCH; bit_offset 0; all counters 0; prev register 0; settle counter 0.
- Pipeline:
  - Each cycle, prev <= tmds_in.
  - cat = {tmds_in, prev} (20 bits).
  - Window = cat[bit_offset+9 : bit_offset], registered as win_q (stage 1).
  - Stage 2 registers the decode of win_q onto the outputs.
  - With bit_offset = 0, a word presented on tmds_in at cycle n appears on the outputs at cycle n+3.
- Control tokens, matched on win_q:
  - 10'b1101010100 -> ctrl 00
  - 10'b0010101011 -> ctrl 01
  - 10'b0101010100 -> ctrl 10
  - 10'b1010101011 -> ctrl 11
- Output decode for a token word (when locked): de_out=0, data_out=0, ctrl_out updated.
- Output decode for any other word (when locked):
  - de_out=1.
  - d = win_q[9] ? ~win_q[7:0] : win_q[7:0].
  - data_out[0] = d[0].
  - data_out[i] = win_q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]), for i = 1..7.
  - ctrl_out holds its previous value.
- Outputs while not locked: data_out and de_out are 0; ctrl_out still updates on tokens.
- FSM SEARCH:
  - run_cnt increments on each token and clears on any non-token.
  - win_cnt increments every counted cycle.
  - run_cnt reaching LOCK_COUNT -> LOCKED, and locked=1 on the next cycle.
  - Otherwise, win_cnt reaching SEARCH_WINDOW-1 -> slip:
    - bit_offset increments, wrapping 9 -> 0;
    - run_cnt and win_cnt clear;
    - settle counter is set to 2.
  - Lock takes priority over slip in the same cycle.
  - While settle > 0 it decrements, and tokens are neither counted nor used for lock. This flushes the stale win_q.
- FSM LOCKED:
  - gap_cnt clears on every token and increments otherwise.
  - gap_cnt reaching LOSS_TIMEOUT -> SEARCH: locked=0, counters cleared, bit_offset retained.
  - Searching resumes from the retained offset.
  - bit_offset never changes while locked.
- Counter widths are $clog2 of their limit + 1. None of them can overflow.
- Reset mid-operation: identical to the power-on reset state, whatever the current state.

Test Plan:
- Alignment at offset 0: reference encoder emits 100 × token 00, then the ramp 0..255 with DE, streamed unshifted. Required: locked=1 after 8 tokens, bit_offset=0, data_out reproduces 0..255 with de_out=1, latency 3 cycles.
- Alignment at offset 7:
  - Same stream rotated by 7 bits, with SEARCH_WINDOW=64 and repeated blanking of 200 tokens every 600 cycles.
  - Required: bit_offset steps 0..7, one step per 64 cycles with no lock at the wrong offsets; locked=1 at 7.
  - After lock, a data word of 0xA5 decodes to 0xA5.
- Control decode: tokens 01, 10, 11 in sequence after lock. Required: ctrl_out = 01, 10, 11, each 3 cycles after input; de_out=0 throughout; ctrl_out holds 11 through the following data period.
- Offset wrap: stream rotated by 3 bits, with no tokens for the first 10×SEARCH_WINDOW cycles. Required: bit_offset wraps 9 -> 0, locked stays 0, then lock is achieved at offset 3 once tokens arrive.
- Loss of lock: after lock, drive only data words for LOSS_TIMEOUT cycles. Required: locked falls exactly at the timeout, de_out is forced 0, bit_offset is retained, and relock occurs after 8 tokens.
- Reset mid-lock: assert rst_pix for 1 cycle while locked. Required: all outputs 0 and bit_offset 0 the next cycle; lock is reacquired normally.
